// File: rtl/t_toggle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : t_toggle_pkg
//  Description : Shared state encoding and default parameters for the
//                push-button toggle-pulse generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package t_toggle_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_SYNC_STAGES     = 2;

endpackage
`default_nettype wire

// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_synchronizer
//  Description : STAGES-deep flop chain bringing an asynchronous level into
//                the clk domain; clears to 0 on rst.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/t_toggle_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : t_toggle_pulse_gen
//  Description : Synchronises and debounces a raw button level and emits one
//                registered toggle pulse per accepted press. Defining
//                T_TOGGLE_RELEASE_PULSE_EN also pulses on accepted release.
//  Revision    : 1.0 - initial release
// ============================================================================
module t_toggle_pulse_gen
    import t_toggle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic t_pulse,
    output logic btn_level,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef T_TOGGLE_RELEASE_PULSE_EN
    localparam logic c_release_pulse = 1'b1;
`else
    localparam logic c_release_pulse = 1'b0;
`endif

    logic             w_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_t_pulse;
    logic             r_btn_level;
    logic             r_busy;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (w_s)
    );

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE_LOW;
            r_cnt       <= '0;
            r_t_pulse   <= 1'b0;
            r_btn_level <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_t_pulse <= 1'b0;
            case (r_state)
                IDLE_LOW: begin
                    if (w_s) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (!w_s) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state     <= IDLE_HIGH;
                        r_cnt       <= '0;
                        r_t_pulse   <= 1'b1;
                        r_btn_level <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!w_s) begin
                        r_state <= WAIT_LOW;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (w_s) begin
                        r_state <= IDLE_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state     <= IDLE_LOW;
                        r_cnt       <= '0;
                        r_t_pulse   <= c_release_pulse;
                        r_btn_level <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= IDLE_LOW;
                    r_cnt       <= '0;
                    r_btn_level <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign t_pulse   = r_t_pulse;
    assign btn_level = r_btn_level;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_t_toggle_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t_toggle_pulse_gen
//  Description : Self-checking bench for t_toggle_pulse_gen (directed
//                scenarios plus randomised button/reset activity).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t_toggle_pulse_gen;

    localparam int DB = 4;
    localparam int SS = 2;
`ifdef T_TOGGLE_RELEASE_PULSE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic t_pulse;
    logic btn_level;
    logic busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    t_toggle_pulse_gen #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .t_pulse   (t_pulse),
        .btn_level (btn_level),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the FSM sees btn_in SS edges late; a new level is accepted
    // once DB consecutive samples differ from the current accepted level.
    bit pipe [SS];
    bit m_level, m_pulse, m_busy;
    int run;

    always @(posedge clk) begin
        bit s;
        s = pipe[SS-1];
        if (rst) begin
            for (int i = 0; i < SS; i++) pipe[i] = 1'b0;
            m_level = 1'b0;
            m_pulse = 1'b0;
            m_busy  = 1'b0;
            run     = 0;
        end else begin
            m_pulse = 1'b0;
            if (s != m_level) begin
                run++;
                if (run == DB) begin
                    m_level = s;
                    m_pulse = s ? 1'b1 : REL;
                    run     = 0;
                end
            end else begin
                run = 0;
            end
            m_busy = (run > 0);
            for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = btn_in;
        end
    end

    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        chk("model_t_pulse", t_pulse, m_pulse);
        chk("model_btn_level", btn_level, m_level);
        chk("model_busy", busy, m_busy);
        if (t_pulse === 1'b1) begin
            chk("no_back_to_back_pulse", prev_pulse, 1'b0);
            pulses++;
        end
        prev_pulse = t_pulse;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Edge-by-edge literal expectations after a clean level change.
    task automatic edge_table(input bit rising, input string tag);
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk({tag, "_t_pulse"}, t_pulse, (e == 6) && (rising || REL));
            chk({tag, "_busy"}, busy, (e >= 3) && (e <= 5));
            chk({tag, "_btn_level"}, btn_level, rising ? (e >= 6) : (e < 6));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        bit bounce [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        int hold;
        @(negedge clk);

        // Reset while the button is already held
        rst = 1'b1; btn_in = 1'b1;
        tick();
        chk("rst_t_pulse", t_pulse, 1'b0);
        chk("rst_btn_level", btn_level, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        pulses = 0;
        edge_table(1'b1, "post_rst");
        idle(10);
        chk("post_rst_one_pulse", pulses == 1, 1'b1);

        // Release after a long hold
        pulses = 0;
        btn_in = 1'b0;
        edge_table(1'b0, "release");
        idle(10);
        chk("release_pulse_count", pulses == (REL ? 1 : 0), 1'b1);

        // Clean press held 20 cycles
        pulses = 0;
        btn_in = 1'b1;
        edge_table(1'b1, "press");
        idle(12);
        chk("press_one_pulse", pulses == 1, 1'b1);
        btn_in = 1'b0;
        idle(12);

        // Bouncing press
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            btn_in = bounce[i];
            tick();
        end
        chk("bounce_no_early_pulse", pulses == 0, 1'b1);
        idle(15);
        chk("bounce_one_pulse", pulses == 1, 1'b1);
        chk("bounce_level_high", btn_level, 1'b1);
        btn_in = 1'b0;
        idle(12);

        // Short glitch
        pulses = 0;
        btn_in = 1'b1;
        idle(3);
        btn_in = 1'b0;
        idle(12);
        chk("glitch_no_pulse", pulses == 0, 1'b1);
        chk("glitch_level_low", btn_level, 1'b0);

        // Reset at edge 4 of a press, button kept held
        pulses = 0;
        btn_in = 1'b1;
        idle(3);
        rst = 1'b1;
        tick();
        chk("midrst_t_pulse", t_pulse, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        edge_table(1'b1, "midrst");
        idle(5);
        chk("midrst_one_pulse", pulses == 1, 1'b1);
        btn_in = 1'b0;
        idle(12);

        // Reset on the edge that would launch the pulse
        pulses = 0;
        btn_in = 1'b1;
        idle(5);
        rst = 1'b1;
        tick();
        chk("pending_pulse_cleared", t_pulse, 1'b0);
        rst = 1'b0;
        idle(12);
        chk("pending_requalified", pulses == 1, 1'b1);
        btn_in = 1'b0;
        idle(12);

        // Randomised button activity with occasional reset
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                btn_in = 1'($urandom_range(0, 1));
                hold   = int'($urandom_range(1, 8));
            end
            hold--;
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
